// File: rtl/enigma_symb_rx.sv
// Receive endpoint for the enigma symbol stream: edge-detects symbol events, checks range and spacing,
// and queues accepted symbols in a FWFT FIFO. Optional macro ENIGMA_RX_ASCII_EN adds rd_ascii_o.
module enigma_symb_rx #(
  parameter int DEPTH = 16,
  parameter int GAP   = 5,
  parameter int CNT_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [5:0]                 symb_i,
  input  logic                       rd_ready_i,
  input  logic                       clr_err_i,
  output logic                       rd_valid_o,
  output logic [5:0]                 rd_symb_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [CNT_W-1:0]           symb_cnt_o,
  output logic                       err_range_o,
  output logic                       err_gap_o,
  output logic                       err_ovf_o
`ifdef ENIGMA_RX_ASCII_EN
  ,
  output logic [7:0]                 rd_ascii_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP) + 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             prev_zero_q, prev_zero_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_range_q, err_range_d;
  logic             err_gap_q, err_gap_d;
  logic             err_ovf_q, err_ovf_d;
  logic [4:0]       mem_q [DEPTH];

  logic evt, window, in_range;
  logic evt_ok, gap_hit, range_bad, wr_req;
  logic pop, full, wr_ok, ovf;

  // A held nonzero value is a single event: only the 0 -> nonzero transition counts.
  assign evt      = (symb_i != 6'd0) && prev_zero_q;
  assign window   = (state_q == IDLE) || (gap_cnt_q == '0);
  assign in_range = ($signed(symb_i) >= 6'sd1) && ($signed(symb_i) <= 6'sd26);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      gap_cnt_q   <= '0;
      prev_zero_q <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      err_range_q <= 1'b0;
      err_gap_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      prev_zero_q <= prev_zero_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      err_range_q <= err_range_d;
      err_gap_q   <= err_gap_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= symb_i[4:0];
  end

  // Next state: an expiring HOLD window behaves exactly like IDLE in that cycle.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    if (!window) begin
      gap_cnt_d = gap_cnt_q - GW'(1);
    end else if (evt) begin
      state_d   = HOLD;
      gap_cnt_d = GAP_LOAD;
    end else begin
      state_d   = IDLE;
    end
  end

  // FSM outputs: event classification
  always_comb begin
    evt_ok    = evt && window;
    gap_hit   = evt && !window;
    range_bad = evt_ok && !in_range;
    wr_req    = evt_ok && in_range;
  end

  // FIFO, counter and sticky flags
  always_comb begin
    prev_zero_d = (symb_i == 6'd0);
    pop         = rd_valid_o && rd_ready_i;
    full        = (level_q == LW'(DEPTH));
    wr_ok       = wr_req && (!full || pop);
    ovf         = wr_req && full && !pop;
    wr_ptr_d    = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({wr_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    cnt_d       = (wr_ok && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    err_range_d = (err_range_q && !clr_err_i) || range_bad;
    err_gap_d   = (err_gap_q && !clr_err_i) || gap_hit;
    err_ovf_d   = (err_ovf_q && !clr_err_i) || ovf;
  end

  assign rd_valid_o  = (level_q != '0);
  assign rd_symb_o   = rd_valid_o ? {1'b0, mem_q[rd_ptr_q]} : 6'd0;
  assign level_o     = level_q;
  assign symb_cnt_o  = cnt_q;
  assign err_range_o = err_range_q;
  assign err_gap_o   = err_gap_q;
  assign err_ovf_o   = err_ovf_q;

`ifdef ENIGMA_RX_ASCII_EN
  assign rd_ascii_o = rd_valid_o ? (8'h40 + {2'b00, rd_symb_o}) : 8'h00;
`endif

endmodule

// File: tb/tb_enigma_symb_rx.sv
// Directed bench for enigma_symb_rx: per-cycle vector table plus hand sequences for full/reset corners.
module tb_enigma_symb_rx;

  logic       clk, rst;
  logic [5:0] symb;
  logic       rdy, clr;
  logic       rd_valid;
  logic [5:0] rd_symb;
  logic [4:0] level;
  logic [7:0] cnt;
  logic       err_range, err_gap, err_ovf;
`ifdef ENIGMA_RX_ASCII_EN
  logic [7:0] rd_ascii;
`endif

  int n_total = 0;
  int n_bad   = 0;
  logic [5:0] exp_q[$];

  typedef struct {
    logic [5:0] symb;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [5:0] es;
    int         el;
    int         ec;
    logic       er, eg, eo;
  } vec_t;

  vec_t tbl[$];

  enigma_symb_rx #(.DEPTH(16), .GAP(5), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .symb_i(symb), .rd_ready_i(rdy), .clr_err_i(clr),
    .rd_valid_o(rd_valid), .rd_symb_o(rd_symb), .level_o(level), .symb_cnt_o(cnt),
    .err_range_o(err_range), .err_gap_o(err_gap), .err_ovf_o(err_ovf)
`ifdef ENIGMA_RX_ASCII_EN
    , .rd_ascii_o(rd_ascii)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [5:0] es, input int el,
                            input int ec, input logic er, input logic eg, input logic eo);
    chk({tag, ".valid"}, int'(rd_valid), int'(ev));
    chk({tag, ".symb"}, int'(rd_symb), int'(es));
    chk({tag, ".level"}, int'(level), el);
    chk({tag, ".cnt"}, int'(cnt), ec);
    chk({tag, ".err_range"}, int'(err_range), int'(er));
    chk({tag, ".err_gap"}, int'(err_gap), int'(eg));
    chk({tag, ".err_ovf"}, int'(err_ovf), int'(eo));
`ifdef ENIGMA_RX_ASCII_EN
    chk({tag, ".ascii"}, int'(rd_ascii), ev ? int'(8'h40) + int'(es) : 0);
`endif
  endtask

  task automatic add(input logic [5:0] s, input logic r, input logic c, input logic ev,
                     input logic [5:0] es, input int el, input int ec,
                     input logic er, input logic eg, input logic eo);
    vec_t v;
    v.symb = s; v.rdy = r; v.clr = c; v.ev = ev; v.es = es;
    v.el = el; v.ec = ec; v.er = er; v.eg = eg; v.eo = eo;
    tbl.push_back(v);
  endtask

  // Driver: apply inputs away from the edge, sample 1 time unit after it.
  task automatic step(input logic [5:0] s, input logic r, input logic c);
    symb = s; rdy = r; clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Spaced events 3,17,26 then three pops
    add(6'd3, 0, 0, 1, 6'd3, 1, 1, 0, 0, 0);
    repeat (4) add(6'd0, 0, 0, 1, 6'd3, 1, 1, 0, 0, 0);
    add(6'd17, 0, 0, 1, 6'd3, 2, 2, 0, 0, 0);
    repeat (4) add(6'd0, 0, 0, 1, 6'd3, 2, 2, 0, 0, 0);
    add(6'd26, 0, 0, 1, 6'd3, 3, 3, 0, 0, 0);
    add(6'd0, 1, 0, 1, 6'd17, 2, 3, 0, 0, 0);
    add(6'd0, 1, 0, 1, 6'd26, 1, 3, 0, 0, 0);
    add(6'd0, 1, 0, 0, 6'd0, 0, 3, 0, 0, 0);
    add(6'd0, 0, 0, 0, 6'd0, 0, 3, 0, 0, 0);
    // Held value is one event
    repeat (4) add(6'd5, 0, 0, 1, 6'd5, 1, 4, 0, 0, 0);
    add(6'd0, 0, 0, 1, 6'd5, 1, 4, 0, 0, 0);
    add(6'd0, 1, 0, 0, 6'd0, 0, 4, 0, 0, 0);
    // Write with ready while empty: no bypass; then gap violation and clear
    add(6'd9, 1, 0, 1, 6'd9, 1, 5, 0, 0, 0);
    add(6'd0, 0, 0, 1, 6'd9, 1, 5, 0, 0, 0);
    add(6'd12, 0, 0, 1, 6'd9, 1, 5, 0, 1, 0);
    add(6'd0, 0, 1, 1, 6'd9, 1, 5, 0, 0, 0);
    add(6'd0, 0, 0, 1, 6'd9, 1, 5, 0, 0, 0);
    add(6'd0, 1, 0, 0, 6'd0, 0, 5, 0, 0, 0);
    // Range errors: -3, 27, then 31 coincident with clear (set wins)
    add(6'h3D, 0, 0, 0, 6'd0, 0, 5, 1, 0, 0);
    repeat (4) add(6'd0, 0, 0, 0, 6'd0, 0, 5, 1, 0, 0);
    add(6'd27, 0, 0, 0, 6'd0, 0, 5, 1, 0, 0);
    add(6'd0, 0, 1, 0, 6'd0, 0, 5, 0, 0, 0);
    repeat (3) add(6'd0, 0, 0, 0, 6'd0, 0, 5, 0, 0, 0);
    add(6'd31, 0, 1, 0, 6'd0, 0, 5, 1, 0, 0);
    add(6'd0, 0, 1, 0, 6'd0, 0, 5, 0, 0, 0);
    repeat (3) add(6'd0, 0, 0, 0, 6'd0, 0, 5, 0, 0, 0);

    rst = 1'b1; symb = 6'd0; rdy = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 6'd0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].symb, tbl[i].rdy, tbl[i].clr);
      check_outs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].es, tbl[i].el, tbl[i].ec,
                 tbl[i].er, tbl[i].eg, tbl[i].eo);
    end

    // Fill to DEPTH, 17th event overflows
    for (int i = 0; i < 17; i++) begin
      step(6'(i + 1), 0, 0);
      if (i < 16) exp_q.push_back(6'(i + 1));
      repeat (4) step(6'd0, 0, 0);
    end
    check_outs("full", 1, exp_q[0], 16, 21, 0, 0, 1);

    // Event coincident with pop while full
    step(6'd20, 1, 0);
    void'(exp_q.pop_front());
    exp_q.push_back(6'd20);
    check_outs("full_pop_wr", 1, exp_q[0], 16, 22, 0, 0, 1);

    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d.valid", k), int'(rd_valid), 1);
      chk($sformatf("drain%0d.symb", k), int'(rd_symb), int'(exp_q[0]));
`ifdef ENIGMA_RX_ASCII_EN
      chk($sformatf("drain%0d.ascii", k), int'(rd_ascii), int'(8'h40) + int'(exp_q[0]));
`endif
      step(6'd0, 1, 0);
      void'(exp_q.pop_front());
    end
    rdy = 1'b0;
    check_outs("drained", 0, 6'd0, 0, 22, 0, 0, 1);

    // Mid-stream asynchronous reset
    step(6'd7, 0, 0);
    repeat (4) step(6'd0, 0, 0);
    step(6'd8, 0, 0);
    check_outs("pre_rst", 1, 6'd7, 2, 24, 0, 0, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outs("async_rst", 0, 6'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(6'd0, 0, 0);
    check_outs("post_rst", 0, 6'd0, 0, 0, 0, 0, 0);
    step(6'd1, 0, 0);
    check_outs("post_rst_evt", 1, 6'd1, 1, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/enigma_symb_rx.md
Name: enigma_symb_rx

Overview:
Receive-side endpoint for the enigma symbol stream. Monitors the signed 6-bit enigma output, where 0 means idle and 1..26 encode A..Z, and captures each new symbol. Checks value range and minimum symbol spacing, then buffers accepted symbols in a first-word-fall-through FIFO with a valid/ready read port. Sits between enigma_1.out_symb_o and the downstream consumer (file writer, UART packer); replaces ad-hoc bench sampling.

Parameters:
DEPTH, 16, FIFO entries (power of 2, >=2)
GAP, 5, minimum clock cycles from one symbol event to the next legal event
CNT_W, 8, width of accepted-symbol counter

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous reset, active-high
symb_i  in  6  signed symbol from enigma out_symb_o; 0 = idle
rd_ready_i  in  1  consumer ready
clr_err_i  in  1  synchronous clear of sticky error flags
rd_valid_o  out  1  FIFO non-empty
rd_symb_o  out  6  head-of-FIFO symbol, 1..26
level_o  out  $clog2(DEPTH)+1  current FIFO occupancy
symb_cnt_o  out  CNT_W  accepted symbols, saturating
err_range_o  out  1  sticky: out-of-range symbol event seen
err_gap_o  out  1  sticky: event arrived inside GAP window
err_ovf_o  out  1  sticky: accepted symbol dropped because FIFO full

Behaviour:
- Reset (async, rst_i=1): FIFO empty, rd_valid_o=0, rd_symb_o=0, level_o=0, symb_cnt_o=0, all err_* = 0, prev_zero=1, FSM=IDLE, gap counter=0.
- Event definition: symb_i != 0 and prev_zero==1. prev_zero is a register holding (symb_i==0) from the previous cycle. A nonzero value held across several cycles is one event.
- FSM IDLE: on an event, classify it, load gap counter with GAP-1, and go to HOLD.
- FSM HOLD: gap counter decrements each cycle. When it reaches 0, return to IDLE; an event in that same cycle is handled as an IDLE event.
  - An event in HOLD sets err_gap_o. The symbol is dropped and the counter is not reloaded.
- Classification:
  - symb_i in 1..26 (signed compare) → accepted.
  - Negative or 27..31 → err_range_o=1, dropped. It still starts the GAP window.
- Write: an accepted symbol is written at the edge where the event is sampled. rd_valid_o and the new head appear the following cycle (1-cycle latency).
- Pop: rd_valid_o & rd_ready_i at an edge.
  - rd_symb_o is stable while rd_valid_o=1 and not popped.
  - rd_symb_o=0 when empty.
- Full boundary:
  - Write while full with no pop → dropped, err_ovf_o=1.
  - Write and pop in the same cycle while full → write accepted, level unchanged.
  - Write and pop in the same cycle while empty → not allowed to bypass; the write lands, level=1 next cycle.
- Pointers wrap modulo DEPTH. level_o ranges 0..DEPTH.
- symb_cnt_o increments per accepted write (not per drop) and saturates at 2^CNT_W-1.
- Sticky errors:
  - clr_err_i clears them.
  - A new error in the same cycle as clr_err_i leaves the flag set (set wins).
  - Errors never affect FIFO contents.
- Reset asserted mid-stream discards FIFO contents and counters immediately.

Optional Feature:
Macro ENIGMA_RX_ASCII_EN.
- Defined: adds output port rd_ascii_o [7:0] = 8'h40 + rd_symb_o when rd_valid_o=1 (1→'A' 0x41, 26→'Z' 0x5A), else 8'h00. Combinational from FIFO head; no added latency.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Send 3,0,0,0,0,17,0,0,0,0,26 at 5-cycle spacing with rd_ready_i=0 → level_o=3; pops yield 3,17,26; symb_cnt_o=3; no errors.
- Hold symb_i=5 for 4 cycles, then 0 → exactly one entry (5); symb_cnt_o=1.
- symb_i=9 then 0 then 12 two cycles later → 12 dropped, err_gap_o=1, FIFO holds only 9. Pulse clr_err_i → err_gap_o=0.
- Events -3 and 27 spaced by GAP → both dropped, err_range_o=1, level_o=0, symb_cnt_o=0.
- 17 legal events with rd_ready_i=0, DEPTH=16 → level_o=16, err_ovf_o=1. With the FIFO full, an event coincident with a pop is accepted and level_o stays 16. Assert rst_i mid-stream → all outputs return to reset values asynchronously.
- With ENIGMA_RX_ASCII_EN: event 1 → rd_ascii_o=0x41; event 26 → 0x5A; empty FIFO → 0x00.
